// File: rtl/relay_mem_pkg.sv
// Shared types and constants for the relay-computer memory bus sequencer.
package relay_mem_pkg;

    localparam int MEM_BYTES  = 32768;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } mem_state_t;

    typedef enum logic {
        SRC_CPU  = 1'b0,
        SRC_BOOT = 1'b1
    } txn_src_t;

    // A boot load can never cover more than the whole memory.
    function automatic logic [15:0] clamp_boot_len(input logic [15:0] len);
        logic [15:0] res;
        if (len > 16'd32768) begin
            res = 16'd32768;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_bus_sequencer_if.sv
// Bus bundle between the sequencer, its two requesters and the memory.
// The slave modport is the sequencer's view, master is the environment's.
interface mem_bus_sequencer_if #(
    parameter int ADDR_W = relay_mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = relay_mem_pkg::DEF_DATA_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [15:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              boot_start;
    logic [15:0]       boot_len;
    logic              boot_valid;
    logic [DATA_W-1:0] boot_data;
    logic              boot_ready;
    logic              load_mem_complete;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wdata_oe;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_read;
    logic              mem_write;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  boot_start, boot_len, boot_valid, boot_data,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, boot_ready, load_mem_complete,
        output mem_addr, mem_wdata, mem_wdata_oe, mem_read, mem_write
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output boot_start, boot_len, boot_valid, boot_data,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, boot_ready, load_mem_complete,
        input  mem_addr, mem_wdata, mem_wdata_oe, mem_read, mem_write
    );

endinterface

// File: rtl/mem_phase_timer.sv
// Loadable down-counter that times one bus phase; tc_o flags a count of zero.
module mem_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Reload on a phase change, otherwise count down and park at zero.
    always_comb begin
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != {CNT_W{1'b0}}) begin
            count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_bus_sequencer.sv
// Arbitrates CPU and boot-loader requests onto the relay memory and runs the
// setup/access/hold strobe phases. Boot loading is compiled in with MEM_BOOT_LOAD_EN.
module mem_bus_sequencer
    import relay_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SETUP_CYC  = 1,
    parameter int ACCESS_CYC = 4,
    parameter int HOLD_CYC   = 1
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_sequencer_if.slave bus
);

    localparam int CNT_W = 8;

    mem_state_t        state_q, state_d;
    txn_src_t          src_q, src_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              oe_q, oe_d;
    logic              ack_q, ack_d;
    logic              boot_ready_q, boot_ready_d;
    logic              complete_q;

    logic              boot_pick_s;
    logic              boot_grant_s;
    logic [ADDR_W-1:0] boot_addr_s;
    logic [DATA_W-1:0] boot_data_s;
    logic              timer_load_s;
    logic [CNT_W-1:0]  timer_val_s;
    logic [CNT_W-1:0]  timer_cnt_s;
    logic              timer_tc_s;
    logic              last_hold_next_s;

    always_comb begin
        case (state_d)
            SETUP:   timer_val_s = CNT_W'(SETUP_CYC - 1);
            ACCESS:  timer_val_s = CNT_W'(ACCESS_CYC - 1);
            HOLD:    timer_val_s = CNT_W'(HOLD_CYC - 1);
            default: timer_val_s = {CNT_W{1'b0}};
        endcase
    end

    assign timer_load_s = (state_d != state_q);

    mem_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load_s),
        .load_val_i (timer_val_s),
        .count_o    (timer_cnt_s),
        .tc_o       (timer_tc_s)
    );

    // State register and transaction latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            src_q        <= SRC_CPU;
            we_q         <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            wdata_q      <= {DATA_W{1'b0}};
            rdata_q      <= {DATA_W{1'b0}};
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            oe_q         <= 1'b0;
            ack_q        <= 1'b0;
            boot_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            read_q       <= read_d;
            write_q      <= write_d;
            oe_q         <= oe_d;
            ack_q        <= ack_d;
            boot_ready_q <= boot_ready_d;
        end
    end

    // Next state; the boot stream has priority in IDLE, no preemption elsewhere.
    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        boot_grant_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (boot_pick_s) begin
                    state_d      = SETUP;
                    src_d        = SRC_BOOT;
                    we_d         = 1'b1;
                    addr_d       = boot_addr_s;
                    wdata_d      = boot_data_s;
                    boot_grant_s = 1'b1;
                end else if (bus.cpu_req) begin
                    state_d = SETUP;
                    src_d   = SRC_CPU;
                    we_d    = bus.cpu_we;
                    addr_d  = bus.cpu_addr[ADDR_W-1:0];
                    wdata_d = bus.cpu_wdata;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                if (timer_tc_s) begin
                    state_d = ACCESS;
                end else begin
                    state_d = SETUP;
                end
            end
            ACCESS: begin
                if (timer_tc_s) begin
                    state_d = HOLD;
                end else begin
                    state_d = ACCESS;
                end
            end
            HOLD: begin
                if (timer_tc_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on phase edges.
    always_comb begin
        read_d  = (state_d == ACCESS) && !we_d;
        write_d = (state_d == ACCESS) && we_d;
        oe_d    = we_d && (state_d != IDLE);
        if (state_q == HOLD) begin
            last_hold_next_s = (timer_cnt_s == CNT_W'(1));
        end else begin
            last_hold_next_s = (HOLD_CYC == 1);
        end
        ack_d = (state_d == HOLD) && (src_d == SRC_CPU) && last_hold_next_s;
        if ((state_q == ACCESS) && timer_tc_s && !we_q) begin
            rdata_d = bus.mem_rdata;
        end else begin
            rdata_d = rdata_q;
        end
        boot_ready_d = boot_grant_s;
    end

`ifdef MEM_BOOT_LOAD_EN
    logic              boot_active_q, boot_active_d;
    logic [ADDR_W-1:0] boot_addr_q, boot_addr_d;
    logic [15:0]       boot_rem_q, boot_rem_d;
    logic [15:0]       boot_len_s;
    logic              boot_done_s;
    logic              complete_d;

    assign boot_pick_s = boot_active_q && bus.boot_valid;
    assign boot_addr_s = boot_addr_q;
    assign boot_data_s = bus.boot_data;
    assign boot_len_s  = clamp_boot_len(bus.boot_len);
    assign boot_done_s = (state_q == HOLD) && timer_tc_s && (src_q == SRC_BOOT);

    // Boot progress: a start pulse always restarts from address 0.
    always_comb begin
        boot_active_d = boot_active_q;
        boot_addr_d   = boot_addr_q;
        boot_rem_d    = boot_rem_q;
        complete_d    = complete_q;
        if (bus.boot_start) begin
            boot_active_d = (boot_len_s != 16'd0);
            boot_addr_d   = {ADDR_W{1'b0}};
            boot_rem_d    = boot_len_s;
            if (boot_len_s != 16'd0) begin
                complete_d = 1'b0;
            end else begin
                complete_d = complete_q;
            end
        end else if (boot_done_s && boot_active_q) begin
            boot_addr_d = boot_addr_q + ADDR_W'(1);
            boot_rem_d  = boot_rem_q - 16'd1;
            if (boot_rem_q == 16'd1) begin
                boot_active_d = 1'b0;
                complete_d    = 1'b1;
            end else begin
                boot_active_d = 1'b1;
            end
        end else begin
            boot_active_d = boot_active_q;
        end
    end

    // Boot counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            boot_active_q <= 1'b0;
            boot_addr_q   <= {ADDR_W{1'b0}};
            boot_rem_q    <= 16'd0;
            complete_q    <= 1'b0;
        end else begin
            boot_active_q <= boot_active_d;
            boot_addr_q   <= boot_addr_d;
            boot_rem_q    <= boot_rem_d;
            complete_q    <= complete_d;
        end
    end
`else
    assign boot_pick_s = 1'b0;
    assign boot_addr_s = {ADDR_W{1'b0}};
    assign boot_data_s = {DATA_W{1'b0}};

    // Without a boot loader memory counts as loaded once reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            complete_q <= 1'b0;
        end else begin
            complete_q <= 1'b1;
        end
    end
`endif

    assign bus.cpu_ack           = ack_q;
    assign bus.cpu_rdata         = rdata_q;
    assign bus.boot_ready        = boot_ready_q;
    assign bus.load_mem_complete = complete_q;
    assign bus.mem_addr          = addr_q;
    assign bus.mem_wdata         = wdata_q;
    assign bus.mem_wdata_oe      = oe_q;
    assign bus.mem_read          = read_q;
    assign bus.mem_write         = write_q;

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Directed bench for mem_bus_sequencer with a byte-array memory model.
module tb_mem_bus_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic both_seen = 1'b0;
    logic [7:0] mem [0:32767];
    logic [7:0] boot_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

`ifdef MEM_BOOT_LOAD_EN
    localparam logic EXP_COMPLETE_AFTER_RESET = 1'b0;
`else
    localparam logic EXP_COMPLETE_AFTER_RESET = 1'b1;
`endif

    mem_bus_sequencer_if bus ();

    mem_bus_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_read && bus.mem_write) both_seen <= 1'b1;
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_txn(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                           output int ack_k, output int wr_n, output int rd_n,
                           output logic [14:0] st_addr, output logic oe_ok);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        ack_k = 0; wr_n = 0; rd_n = 0; st_addr = 15'd0; oe_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.mem_write) begin
                wr_n++;
                st_addr = bus.mem_addr;
                if (!bus.mem_wdata_oe) oe_ok = 1'b0;
            end
            if (bus.mem_read) begin
                rd_n++;
                st_addr = bus.mem_addr;
                if (bus.mem_wdata_oe) oe_ok = 1'b0;
            end
            if (bus.cpu_ack) begin
                ack_k = k;
                break;
            end
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic run_cpu(input string tag, input logic we, input logic [15:0] addr,
                           input logic [7:0] wdata, input logic [14:0] exp_addr);
        int ack_k, wr_n, rd_n;
        logic [14:0] st_addr;
        logic oe_ok;
        cpu_txn(we, addr, wdata, ack_k, wr_n, rd_n, st_addr, oe_ok);
        check({tag, "_ack_cycle"}, ack_k, 32'd6);
        check({tag, "_write_cycles"}, wr_n, we ? 32'd4 : 32'd0);
        check({tag, "_read_cycles"}, rd_n, we ? 32'd0 : 32'd4);
        check({tag, "_addr"}, {17'd0, st_addr}, {17'd0, exp_addr});
        check({tag, "_oe"}, {31'd0, oe_ok}, 32'd1);
        tick();
        check({tag, "_ack_pulse"}, {31'd0, bus.cpu_ack}, 32'd0);
    endtask

    initial begin
        int ack_k, br_k, n_ready, n_w, last_w_k, comp_k, idx;
        logic [14:0] waddr [8];
        logic prev_w;

        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'd0; bus.cpu_wdata = 8'd0;
        bus.boot_start = 1'b0; bus.boot_len = 16'd0; bus.boot_valid = 1'b0; bus.boot_data = 8'd0;
        repeat (3) tick();

        check("rst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("rst_oe_ack_ready", {29'd0, bus.mem_wdata_oe, bus.cpu_ack, bus.boot_ready}, 32'd0);
        check("rst_addr", {17'd0, bus.mem_addr}, 32'd0);
        check("rst_data", {16'd0, bus.mem_wdata, bus.cpu_rdata}, 32'd0);
        check("rst_complete", {31'd0, bus.load_mem_complete}, 32'd0);
        reset = 1'b0;
        tick();
        check("complete_after_reset", {31'd0, bus.load_mem_complete}, {31'd0, EXP_COMPLETE_AFTER_RESET});

        run_cpu("wr_0123", 1'b1, 16'h0123, 8'h5A, 15'h0123);
        run_cpu("rd_8123", 1'b0, 16'h8123, 8'h00, 15'h0123);
        check("rd_8123_data", {24'd0, bus.cpu_rdata}, 32'h5A);
        run_cpu("wr_7fff", 1'b1, 16'h7FFF, 8'hC3, 15'h7FFF);
        run_cpu("rd_7fff", 1'b0, 16'h7FFF, 8'h00, 15'h7FFF);
        check("rd_7fff_data", {24'd0, bus.cpu_rdata}, 32'hC3);
        run_cpu("wr_0010", 1'b1, 16'h0010, 8'hA5, 15'h0010);

        // Reset asserted during the second ACCESS cycle of a write.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0200; bus.cpu_wdata = 8'h77;
        repeat (3) tick();
        check("midrst_pre_write", {31'd0, bus.mem_write}, 32'd1);
        reset = 1'b1;
        bus.cpu_req = 1'b0;
        tick();
        check("midrst_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        check("midrst_oe_ack", {30'd0, bus.mem_wdata_oe, bus.cpu_ack}, 32'd0);
        reset = 1'b0;
        tick();
        check("midrst_complete", {31'd0, bus.load_mem_complete}, {31'd0, EXP_COMPLETE_AFTER_RESET});
        run_cpu("post_rst_rd", 1'b0, 16'h0123, 8'h00, 15'h0123);
        check("post_rst_rd_data", {24'd0, bus.cpu_rdata}, 32'h5A);

`ifdef MEM_BOOT_LOAD_EN
        // Four-byte boot load into addresses 0..3.
        bus.boot_len = 16'd4; bus.boot_start = 1'b1; bus.boot_valid = 1'b1;
        idx = 0; bus.boot_data = boot_bytes[0];
        n_ready = 0; n_w = 0; last_w_k = 0; comp_k = 0; prev_w = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            bus.boot_start = 1'b0;
            if (bus.boot_ready) begin
                n_ready++;
                idx++;
                if (idx < 4) bus.boot_data = boot_bytes[idx];
                else bus.boot_valid = 1'b0;
            end
            if (bus.mem_write) begin
                if (!prev_w && n_w < 8) begin
                    waddr[n_w] = bus.mem_addr;
                    n_w++;
                end
                last_w_k = k;
            end
            prev_w = bus.mem_write;
            if (bus.load_mem_complete && comp_k == 0) comp_k = k;
        end
        check("boot_ready_count", n_ready, 32'd4);
        check("boot_write_count", n_w, 32'd4);
        for (int i = 0; i < 4; i++) check("boot_write_addr", {17'd0, waddr[i]}, i);
        check("boot_complete_after_hold", comp_k, last_w_k + 2);
        for (int i = 0; i < 4; i++) begin
            run_cpu("boot_rd", 1'b0, 16'(i), 8'h00, 15'(i));
            check("boot_rd_data", {24'd0, bus.cpu_rdata}, {24'd0, boot_bytes[i]});
        end

        // Boot restart and CPU read in the same IDLE cycle: CPU first.
        bus.boot_len = 16'd1; bus.boot_start = 1'b1; bus.boot_valid = 1'b1; bus.boot_data = 8'h99;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        ack_k = 0; br_k = 0; n_w = 0; comp_k = 0; waddr[0] = 15'h7FFF;
        for (int k = 1; k <= 20; k++) begin
            tick();
            bus.boot_start = 1'b0;
            if (k == 1) check("sim_complete_cleared", {31'd0, bus.load_mem_complete}, 32'd0);
            if (bus.cpu_ack && ack_k == 0) begin
                ack_k = k;
                bus.cpu_req = 1'b0;
                check("sim_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'hA5);
            end
            if (bus.boot_ready && br_k == 0) begin
                br_k = k;
                bus.boot_valid = 1'b0;
            end
            if (bus.mem_write && n_w == 0) begin
                waddr[0] = bus.mem_addr;
                n_w = 1;
            end
            if (bus.load_mem_complete && comp_k == 0) comp_k = k;
        end
        check("sim_cpu_ack_cycle", ack_k, 32'd6);
        check("sim_boot_ready_cycle", br_k, 32'd8);
        check("sim_boot_addr", {17'd0, waddr[0]}, 32'd0);
        check("sim_complete_cycle", comp_k, 32'd14);
        run_cpu("sim_rd0", 1'b0, 16'h0000, 8'h00, 15'h0000);
        check("sim_rd0_data", {24'd0, bus.cpu_rdata}, 32'h99);
`else
        // Boot inputs are ignored; the CPU is still served with boot_valid high.
        bus.boot_len = 16'd4; bus.boot_start = 1'b1; bus.boot_valid = 1'b1; bus.boot_data = 8'h11;
        n_ready = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            bus.boot_start = 1'b0;
            if (bus.boot_ready) n_ready++;
        end
        check("off_boot_ready", n_ready, 32'd0);
        run_cpu("off_rd", 1'b0, 16'h0010, 8'h00, 15'h0010);
        check("off_rd_data", {24'd0, bus.cpu_rdata}, 32'hA5);
        check("off_boot_ready_end", {31'd0, bus.boot_ready}, 32'd0);
        bus.boot_valid = 1'b0;
`endif

        check("never_both_strobes", {31'd0, both_seen}, 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
